// File: rtl/ula_divisor_seq.sv
// ula_divisor_seq: sequential 4-bit unsigned divider slice of the ULA.
// It performs one restoring step per clock, so a division takes 4 DIV cycles.
// Divide-by-zero, the invalid opcode and the opcodes this unit does not handle
// skip DIV and finish in one cycle with the error flag set accordingly.
module ula_divisor_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] seletor,
  input  logic       start,
  output logic [3:0] quociente,
  output logic [3:0] resto,
  output logic       busy,
  output logic       done,
  output logic       ledr9
);

  localparam logic [2:0] SEL_DIV = 3'b110;
  localparam logic [2:0] SEL_INV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // r_a starts as the dividend; quotient bits shift in from the LSB as
  // dividend bits shift out of the MSB, so after 4 steps it holds the quotient.
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_sel;
  logic [4:0] r_rem;
  logic [1:0] r_cnt;

  logic [4:0] w_rem_shift;
  logic [4:0] w_rem_step;
  logic       w_qbit;
  logic       w_go_div;

  // A request enters DIV only for a real division with a non-zero divisor.
  always_comb begin
    w_go_div = (seletor == SEL_DIV) && (b != 4'd0);
  end

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_shift = {r_rem[3:0], r_a[3]};
    // A set bit shifted out of r_rem would mean the value already exceeds b.
    w_qbit      = r_rem[4] | (w_rem_shift >= {1'b0, r_b});
    w_rem_step  = w_qbit ? (w_rem_shift - {1'b0, r_b}) : w_rem_shift;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_go_div ? DIV : DONE;
      DIV:     if (r_cnt == 2'd3) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    busy = (r_state == DIV);
    done = (r_state == DONE);
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the internal operand/remainder/counter registers are reset too,
      // so the block comes out of reset in a fully known state.
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_sel     <= 3'd0;
      r_rem     <= 5'd0;
      r_cnt     <= 2'd0;
      quociente <= 4'd0;
      resto     <= 4'd0;
      ledr9     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_sel <= seletor;
            r_rem <= 5'd0;
            r_cnt <= 2'd0;
            if (w_go_div) begin
              ledr9 <= 1'b0;
            end else begin
              // Bypass: zero result; flag only divide-by-zero or invalid op.
              quociente <= 4'd0;
              resto     <= 4'd0;
              ledr9     <= (seletor == SEL_INV) || (seletor == SEL_DIV);
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_step;
          r_a   <= {r_a[2:0], w_qbit};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            quociente <= {r_a[2:0], w_qbit};
            resto     <= w_rem_step[3:0];
            ledr9     <= (r_sel != SEL_DIV);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_divisor_seq.sv
// Directed testbench for ula_divisor_seq: latency, results, error flags,
// start-ignore behaviour, mid-operation reset and a full operand sweep.
module tb_ula_divisor_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] seletor;
  logic       start;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       busy;
  logic       done;
  logic       ledr9;

  int n_tests = 0;
  int n_fail  = 0;

  ula_divisor_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .seletor   (seletor),
    .start     (start),
    .quociente (quociente),
    .resto     (resto),
    .busy      (busy),
    .done      (done),
    .ledr9     (ledr9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start pulse and waits (bounded) for done. lat counts clock
  // edges from the start sample to the cycle in which done is seen.
  // Returns sampled at the negedge inside the DONE cycle.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [2:0] ts, output int lat,
                        output int busy_cnt, output logic got_done);
    @(negedge clk);
    a = ta; b = tb_v; seletor = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat      = k;
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 4'd0; b = 4'd0; seletor = 3'd0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({quociente, resto, busy, done, ledr9} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b ledr9=%b, want all 0",
               quociente, resto, busy, done, ledr9);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc; logic gd;
    run_op(4'd13, 4'd3, 3'b110, lat, bc, gd);
    n_tests++;
    if (!gd || lat != 5) begin
      n_fail++;
      $display("FAIL basic_latency: got done=%b lat=%0d, want done at 5", gd, lat);
    end
    n_tests++;
    if (bc != 4) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d, want 4", bc);
    end
    n_tests++;
    if (quociente !== 4'd4 || resto !== 4'd1 || ledr9 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d ledr9=%b, want q=4 r=1 ledr9=0",
               quociente, resto, ledr9);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done still %b one cycle later, want 0", done);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (quociente !== 4'd4 || resto !== 4'd1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got q=%0d r=%0d busy=%b done=%b, want q=4 r=1 idle",
               quociente, resto, busy, done);
    end
  endtask

  task automatic test_edges();
    logic [3:0] va [3] = '{4'd15, 4'd2, 4'd0};
    logic [3:0] vb [3] = '{4'd1,  4'd7, 4'd5};
    logic [3:0] vq [3] = '{4'd15, 4'd0, 4'd0};
    logic [3:0] vr [3] = '{4'd0,  4'd2, 4'd0};
    int lat, bc; logic gd;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 3'b110, lat, bc, gd);
      n_tests++;
      if (!gd || lat != 5 || quociente !== vq[i] || resto !== vr[i] || ledr9 !== 1'b0) begin
        n_fail++;
        $display("FAIL edge_%0d_%0d: got done=%b lat=%0d q=%0d r=%0d ledr9=%b, want lat=5 q=%0d r=%0d ledr9=0",
                 va[i], vb[i], gd, lat, quociente, resto, ledr9, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] vs [3] = '{3'b110, 3'b111, 3'b000};
    logic       vl [3] = '{1'b1, 1'b1, 1'b0};
    int lat, bc; logic gd;
    // Leave a non-zero result behind so the zeroing is observable.
    run_op(4'd13, 4'd3, 3'b110, lat, bc, gd);
    for (int i = 0; i < 3; i++) begin
      run_op(4'd9, 4'd0, vs[i], lat, bc, gd);
      n_tests++;
      if (!gd || lat != 1 || bc != 0 || quociente !== 4'd0 || resto !== 4'd0 || ledr9 !== vl[i]) begin
        n_fail++;
        $display("FAIL error_sel_%b: got done=%b lat=%0d busy_cycles=%0d q=%0d r=%0d ledr9=%b, want lat=1 busy=0 q=0 r=0 ledr9=%b",
                 vs[i], gd, lat, bc, quociente, resto, ledr9, vl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int late_busy = 0;
    int seen_at = 0;
    logic [3:0] q_s = 4'd0, r_s = 4'd0;
    @(negedge clk);
    a = 4'd13; b = 4'd3; seletor = 3'b110; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Keep start high and change operands throughout DIV and DONE.
    a = 4'd7; b = 4'd2;
    for (int k = 1; k <= 14; k++) begin
      if (seen_at != 0 && k == seen_at + 1) start = 1'b0;
      if (seen_at != 0 && k > seen_at && busy) late_busy++;
      if (done) begin
        n_done++;
        if (seen_at == 0) begin
          seen_at = k; q_s = quociente; r_s = resto;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (q_s !== 4'd4 || r_s !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_result: got q=%0d r=%0d, want q=4 r=1", q_s, r_s);
    end
    n_tests++;
    if (n_done != 1 || seen_at != 5) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d pulses first at %0d, want 1 pulse at 5", n_done, seen_at);
    end
    n_tests++;
    if (late_busy != 0) begin
      n_fail++;
      $display("FAIL b2b_no_restart: busy seen %0d cycles after done, want 0", late_busy);
    end
  endtask

  task automatic test_abort();
    int lat, bc; logic gd;
    int bad_done = 0;
    @(negedge clk);
    a = 4'd13; b = 4'd3; seletor = 3'b110; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({quociente, resto, busy, done, ledr9} !== 11'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got q=%0d r=%0d busy=%b done=%b ledr9=%b, want all 0",
               quociente, resto, busy, done, ledr9);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) bad_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy) bad_done++;
    end
    n_tests++;
    if (bad_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", bad_done);
    end
    run_op(4'd7, 4'd2, 3'b110, lat, bc, gd);
    n_tests++;
    if (!gd || lat != 5 || quociente !== 4'd3 || resto !== 4'd1 || ledr9 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover: got done=%b lat=%0d q=%0d r=%0d ledr9=%b, want lat=5 q=3 r=1 ledr9=0",
               gd, lat, quociente, resto, ledr9);
    end
  endtask

  task automatic test_sweep();
    int lat, bc; logic gd;
    int exp_q, exp_r, exp_lat;
    logic exp_l;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(ia[3:0], ib[3:0], 3'b110, lat, bc, gd);
        if (ib == 0) begin
          exp_q = 0; exp_r = 0; exp_l = 1'b1; exp_lat = 1;
        end else begin
          exp_q = ia / ib; exp_r = ia % ib; exp_l = 1'b0; exp_lat = 5;
        end
        n_tests++;
        if (!gd || lat != exp_lat || int'(quociente) != exp_q || int'(resto) != exp_r || ledr9 !== exp_l) begin
          n_fail++;
          $display("FAIL sweep_%0d_%0d: got done=%b lat=%0d q=%0d r=%0d ledr9=%b, want lat=%0d q=%0d r=%0d ledr9=%b",
                   ia, ib, gd, lat, quociente, resto, ledr9, exp_lat, exp_q, exp_r, exp_l);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_errors();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_divisor_seq.md
ULA_DIVISOR_SEQ -- requirements
Module: ula_divisor_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 a  in  4  dividend, unsigned.
REQ-005 b  in  4  divisor, unsigned.
REQ-006 seletor  in  3  ULA operation code; 3'b110 = divide, 3'b111 = invalid, others = not handled here.
REQ-007 start  in  1  request pulse; sampled only in IDLE.
REQ-008 quociente  out  4  registered quotient.
REQ-009 resto  out  4  registered remainder.
REQ-010 busy  out  1  high while the division iterates.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 ledr9  out  1  registered error flag: divide-by-zero or invalid operation.

Function
REQ-013 SHALL implement states IDLE, DIV and DONE; the state register SHALL be 2 bits.
REQ-014 IDLE with start=1 at edge E0 SHALL latch a, b and seletor into internal registers; later input changes SHALL NOT affect the operation.
REQ-015 At E0, seletor=110 with b!=0 SHALL go to DIV, clear the 5-bit partial remainder and the 2-bit iteration counter, and clear ledr9.
REQ-016 At E0, seletor=110 with b=0 SHALL go directly to DONE with quociente=0, resto=0 and ledr9=1.
REQ-017 At E0, seletor=111 SHALL go directly to DONE with quociente=0, resto=0 and ledr9=1.
REQ-018 At E0, any other seletor SHALL go directly to DONE with quociente=0, resto=0 and ledr9=0.
REQ-019 Each DIV cycle SHALL perform one restoring step, MSB first:
  - rem = {rem[3:0], next dividend bit};
  - if rem >= {0,b}, subtract b and set the quotient bit to 1; otherwise set it to 0.
REQ-020 DIV SHALL last exactly 4 cycles (E1..E4). At E4 the state SHALL go to DONE, with quociente and resto loaded from the final values.
REQ-021 Division latency: done SHALL be high in the cycle after E4, i.e. 5 edges after the start sample. Error or bypass latency: done SHALL be high in the cycle after E0.
REQ-022 done SHALL be high only in DONE, for exactly one cycle. DONE SHALL then return unconditionally to IDLE.
REQ-023 busy SHALL be high only in DIV.
REQ-024 start SHALL be ignored in DIV and DONE; it is not queued. In particular, start=1 during DONE SHALL NOT start a new operation.
REQ-025 quociente, resto and ledr9 SHALL hold their last values until the next operation updates them.
REQ-026 During DIV, quociente, resto and ledr9 SHALL be updated no earlier than the transition to DONE.
REQ-027 Results SHALL satisfy quociente*b + resto = a and resto < b for every b!=0, including a=0 and a<b.
REQ-028 No arithmetic SHALL overflow: the partial remainder is 5 bits wide, and a 4-bit quotient always suffices for 4-bit unsigned operands.
REQ-029 Asserting rst_n low mid-operation SHALL abort the operation immediately, with no done pulse.

Reset
REQ-030 While rst_n=0: state=IDLE, and quociente, resto, busy, done and ledr9 SHALL all be 0; internal operand, remainder and counter registers SHALL also be 0.
REQ-031 After rst_n deasserts, the first start sampled in IDLE SHALL be accepted.

Verification
REQ-032 a=13, b=3, seletor=110, start pulse -> busy high for 4 cycles; then done=1 with quociente=4, resto=1, ledr9=0, 5 edges after start.
REQ-033 Edge values, each with seletor=110:
  - a=15, b=1 -> quociente=15, resto=0;
  - a=2, b=7 -> quociente=0, resto=2;
  - a=0, b=5 -> quociente=0, resto=0.
REQ-034 a=9, b=0, seletor=110 -> done and ledr9=1 one cycle after start, busy never high, quociente=0, resto=0. Then seletor=111 -> ledr9=1. Then seletor=000 -> ledr9=0.
REQ-035 Start a=13, b=3, then start again plus change a and b during DIV -> result still 4 r 1; exactly one done pulse; no second operation.
REQ-036 rst_n low at the 2nd DIV cycle -> all outputs 0 immediately; no done pulse. After release, a=7, b=2 -> quociente=3, resto=1.
REQ-037 Exhaustive sweep of all 256 a/b pairs with seletor=110 -> REQ-027 holds for b!=0, and ledr9=1 exactly when b=0.
